mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage load/store sequencer sitting directly upstream of the byte-wide data memory.
- Accepts one 32-bit word or byte load/store request from the MEM pipeline stage.
- Breaks each request into sequential single-byte accesses (little-endian), assembles load data into a 32-bit result, and signals completion.
- Stalls the pipeline via req_ready while busy.

Parameters:
- ADDR_W, 32, address width of requests and of the memory address port.
- DATA_W, 32, request and response data width (4 bytes).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- rsp_rdata  out  DATA_W  load result; zero for stores.
- mem_addr  out  ADDR_W  byte address to data memory.
- mem_wdata  out  8  byte to write.
- mem_read_en  out  1  byte read strobe.
- mem_write_en  out  1  byte write strobe.
- mem_rdata  in  8  read byte; valid in the cycle after mem_read_en, sampled at the end of that cycle.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; mem_addr=0; mem_wdata=0; mem_read_en=0; mem_write_en=0.
  - Byte counter and assembly register are cleared.
- Accept: the edge where req_valid && req_ready is high.
  - Base address, write data, req_write and req_byte are latched at that edge.
  - Later changes on the req_* inputs are ignored.
  - T1 is the first cycle after the accept edge.
- Word accesses: base = req_addr with bits [1:0] forced to 0 (misaligned address silently aligned). Byte count is 4.
- Byte accesses: base = req_addr unmodified. Byte count is 1.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR, RESP.
- IDLE:
  - Accept with req_write=0 goes to RD_ISSUE.
  - Accept with req_write=1 goes to WR.
  - Otherwise stay in IDLE.
- RD_ISSUE:
  - mem_read_en=1 and mem_addr=base+idx each cycle; idx increments each edge.
  - After the last byte is issued, go to RD_DRAIN.
  - Each sampled mem_rdata is written to assembly bits [8*i+7:8*i], where i is the byte index issued in the previous cycle.
- RD_DRAIN: mem_read_en=0; samples the final byte, then goes to RESP.
- WR:
  - mem_write_en=1, mem_addr=base+idx, mem_wdata=wdata[8*idx+7:8*idx].
  - After the last byte is written, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata holds the assembled word.
  - Byte loads are zero-extended to 32 bits.
  - Stores return rsp_rdata=0.
  - Next state is IDLE. req_ready stays 0 in RESP, so back-to-back requests have one idle cycle between them.
- Latency from accept edge:
  - Word load: issues T1–T4, rsp_valid in T6.
  - Byte load: issue T1, rsp_valid in T3.
  - Word store: writes T1–T4, rsp_valid in T5.
  - Byte store: write T1, rsp_valid in T2.
- Invariants:
  - mem_read_en and mem_write_en are never both high.
  - Both enables are low in IDLE, RD_DRAIN and RESP.
- Address arithmetic: base+idx is computed at ADDR_W bits and wraps modulo 2^ADDR_W. With word alignment, a word access never crosses the top of the address space.
- Reset mid-operation:
  - Abort immediately; enables are low from the cycle after the reset edge.
  - No rsp_valid is produced.
  - Bytes already written remain in memory (partial store is permitted and documented).
- req_valid while not ready: ignored, no queuing. The requester holds the request until req_ready.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum type (IDLE, RD_ISSUE, RD_DRAIN, WR, RESP);
  - constants WORD_BYTES=4 and BYTE_W=8;
  - the byte-count select function (byte ? 1 : 4).
- No sub-module: the FSM, counter and assembly register form one block.

Test Plan:
- Preload bytes 0x78,0x56,0x34,0x12 at 0x100–0x103; word load 0x100 -> mem_read_en T1–T4 at 0x100..0x103; rsp_valid T6 with rsp_rdata=0x12345678.
- Same preload; byte load 0x102 -> single read at 0x102 in T1; rsp_valid T3 with rsp_rdata=0x00000034.
- Word store 0xAABBCCDD at 0x200 -> writes 0xDD@0x200, 0xCC@0x201, 0xBB@0x202, 0xAA@0x203 in T1–T4; rsp_valid T5 with rsp_rdata=0.
- Byte store 0xFFFFFF5A at 0x203 -> single write of 0x5A@0x203 in T1; rsp_valid T2; no other memory changes.
- Misaligned word load at 0x101 -> accesses 0x100..0x103; same result as scenario 1 (0x12345678).
- Word store 0xAABBCCDD at 0x200 with rst high at the end of T2 -> only 0x200 and 0x201 written; enables low from T3; req_ready=1; no rsp_valid. A following byte load of 0x201 returns 0x000000CC.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state type, sizes and byte-count helper for the memory access sequencer
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR, RESP} state_t;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W = 8;
  function automatic logic [2:0] byte_count(input logic is_byte);
    return is_byte ? 3'd1 : 3'(WORD_BYTES);
  endfunction
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: splits word/byte load-store requests into sequential little-endian byte accesses
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [7:0]        mem_rdata
);
  state_t state, next_state;
  logic [ADDR_W-1:0] base;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] wdata_q, asm_q;
  logic write_q, byte_q, accept, last;
  logic [2:0] idx;
  logic [1:0] prev;
  assign accept = state == IDLE && req_valid;
  assign last = idx == byte_count(byte_q) - 3'd1;
  assign prev = idx[1:0] - 2'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      wdata_q <= '0;
      asm_q <= '0;
      write_q <= 1'b0;
      byte_q <= 1'b0;
      idx <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        base <= req_byte ? req_addr : {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= req_wdata;
        write_q <= req_write;
        byte_q <= req_byte;
        idx <= '0;
        asm_q <= '0;
      end
      if (state == RD_ISSUE || state == WR) idx <= idx + 3'd1;
      // read data lags its strobe by one cycle, so it belongs to the previously issued index
      if ((state == RD_ISSUE && idx != 3'd0) || state == RD_DRAIN) asm_q[prev] <= mem_rdata;
    end
  end
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (req_valid) next_state = req_write ? WR : RD_ISSUE;
      RD_ISSUE: if (last) next_state = RD_DRAIN;
      RD_DRAIN: next_state = RESP;
      WR:       if (last) next_state = RESP;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end
  assign req_ready = state == IDLE;
  assign mem_read_en = state == RD_ISSUE;
  assign mem_write_en = state == WR;
  assign rsp_valid = state == RESP;
  assign mem_addr = (mem_read_en || mem_write_en) ? base + ADDR_W'(idx) : '0;
  assign mem_wdata = mem_write_en ? wdata_q[idx[1:0]] : '0;
  assign rsp_rdata = (rsp_valid && !write_q) ? asm_q : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector bench with a byte-wide memory model behind the sequencer
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, mem_read_en, mem_write_en;
  logic [31:0] rsp_rdata, mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic pe = 1'b0;
  logic [31:0] pa = '0;
  logic [7:0] pd = '0;
  logic [7:0] mem [0:1023];
  int checks = 0, errors = 0;
  int lat, nacc;
  logic [31:0] rd;
  logic [31:0] acc_addr [0:7];
  logic [7:0] acc_data [0:7];
  logic both_hi, ready_busy;

  typedef struct {
    logic w;
    logic b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int exp_lat;
    int exp_n;
    logic [31:0] exp_a0;
  } vec_t;
  vec_t vecs [0:6];

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pe) mem[pa[9:0]] <= pd;
    else if (mem_write_en) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem_read_en ? mem[mem_addr[9:0]] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    pe = 1'b1; pa = a; pd = d;
    @(negedge clk);
    pe = 1'b0;
  endtask

  task automatic run_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h0BAD_F00D;
    lat = -1; nacc = 0; rd = 'x; both_hi = 1'b0; ready_busy = 1'b0;
    for (int t = 1; t <= 10 && lat < 0; t++) begin
      if ((mem_read_en || mem_write_en) && nacc < 8) begin
        acc_addr[nacc] = mem_addr;
        acc_data[nacc] = mem_wdata;
        nacc++;
      end
      if (mem_read_en && mem_write_en) both_hi = 1'b1;
      if (req_ready) ready_busy = 1'b1;
      if (rsp_valid) begin
        lat = t;
        rd = rsp_rdata;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic seq_ok, rsp_seen;
    logic [31:0] wd;
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h12345678, 6, 4, 32'h100};
    vecs[1] = '{1'b0, 1'b1, 32'h102, 32'h0,        32'h00000034, 3, 1, 32'h102};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'hAABBCCDD, 32'h0,        5, 4, 32'h200};
    vecs[3] = '{1'b1, 1'b1, 32'h203, 32'hFFFFFF5A, 32'h0,        2, 1, 32'h203};
    vecs[4] = '{1'b0, 1'b0, 32'h101, 32'h0,        32'h12345678, 6, 4, 32'h100};
    vecs[5] = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h5ABBCCDD, 6, 4, 32'h200};
    vecs[6] = '{1'b0, 1'b1, 32'h201, 32'h0,        32'h000000CC, 3, 1, 32'h201};
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp", {30'd0, rsp_valid, mem_read_en | mem_write_en}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);

    for (int v = 0; v < 7; v++) begin
      run_req(vecs[v].w, vecs[v].b, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("v%0d_count", v), 32'(nacc), 32'(vecs[v].exp_n));
      seq_ok = 1'b1;
      wd = vecs[v].wdata;
      for (int k = 0; k < nacc; k++) begin
        if (acc_addr[k] !== vecs[v].exp_a0 + 32'(k)) seq_ok = 1'b0;
        if (vecs[v].w && acc_data[k] !== wd[8*k +: 8]) seq_ok = 1'b0;
      end
      chk($sformatf("v%0d_access_seq", v), {31'd0, seq_ok}, 32'd1);
      chk($sformatf("v%0d_enables_excl", v), {31'd0, both_hi}, 32'd0);
      chk($sformatf("v%0d_ready_busy", v), {31'd0, ready_busy}, 32'd0);
      if (v == 2) chk("mem_200_word", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'hAABBCCDD);
      if (v == 3) chk("mem_200_after_byte", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'h5ABBCCDD);
    end

    poke(32'h200, 8'h00); poke(32'h201, 8'h00); poke(32'h202, 8'h00); poke(32'h203, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h200; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    rsp_seen = 1'b0;
    repeat (6) begin
      if (rsp_valid) rsp_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", {31'd0, rsp_seen}, 32'd0);
    chk("abort_partial", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'h0000CCDD);
    run_req(1'b0, 1'b1, 32'h201, 32'h0);
    chk("abort_reload_latency", 32'(lat), 32'd3);
    chk("abort_reload_rdata", rd, 32'h000000CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
